// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the synchronous FIFO.
//                - fifo_status_t : bundled status flags for consumers that
//                                  pass FIFO status around as one value.
//                - next_ptr()    : modulo-DEPTH pointer increment. It wraps
//                                  correctly for non-power-of-two depths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // The wrap test uses >= rather than == so that an out-of-range pointer
    // recovers to 0 instead of running away.
    function automatic logic [31:0] next_ptr(input logic [31:0] ptr,
                                             input int unsigned depth);
        if (ptr >= (depth - 32'd1)) begin
            return 32'd0;
        end
        return ptr + 32'd1;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr
//  Description : Wrapping pointer counter, 0 .. DEPTH-1.
//                The FIFO uses one instance as the write pointer and one as
//                the read pointer.
//  Ports       : clock - sole clock (posedge)
//                reset - asynchronous active-high reset, ptr -> 0
//                clear - synchronous flush, ptr -> 0, overrides inc
//                inc   - advance the pointer by one, modulo DEPTH
//                ptr   - current pointer value
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] r_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (clear) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= AW'(next_ptr(32'(r_ptr), DEPTH));
        end
    end

    assign ptr = r_ptr;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync
//  Description : Single-clock, first-word-fall-through FIFO with occupancy
//                count, full/empty and threshold flags, and registered
//                overflow/underflow error pulses.
//  Ports       : clock        - sole clock (posedge)
//                reset        - asynchronous active-high reset
//                clear        - synchronous flush, overrides we/re
//                we / data_in - push request and the word to push
//                re           - pop request (consumes the head word)
//                data_out     - head word, 0 when empty (combinational)
//                full / empty - count == DEPTH / count == 0
//                almost_full  - count >= AF_LEVEL
//                almost_empty - count <= AE_LEVEL
//                count        - occupancy, 0 .. DEPTH
//                overflow     - one-cycle pulse after a rejected push
//                underflow    - one-cycle pulse after a rejected pop
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DW       = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int AW       = $clog2(DEPTH),
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          we,
    input  logic [DW-1:0] data_in,
    input  logic          re,
    output logic [DW-1:0] data_out,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);
    localparam logic [CW-1:0] c_af_cnt   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] c_ae_cnt   = CW'(AE_LEVEL);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] w_wr_ptr;
    logic [AW-1:0] w_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    fifo_status_t  w_status;

    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);

    // A push into a full FIFO is still accepted when a pop frees the head
    // slot on the same edge. A pop from an empty FIFO is always rejected,
    // even when a push arrives on the same edge.
    assign w_push_ok = we && (!w_full || re);
    assign w_pop_ok  = re && !w_empty;

    fifo_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (w_push_ok),
        .ptr   (w_wr_ptr)
    );

    fifo_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (w_pop_ok),
        .ptr   (w_rd_ptr)
    );

    // Storage is not reset. When full with a simultaneous push and pop,
    // wr_ptr equals rd_ptr; the head has already been consumed on that
    // edge, so overwriting that slot is safe.
    always_ff @(posedge clock) begin
        if (w_push_ok && !clear) begin
            r_mem[w_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
            r_overflow  <= we && !w_push_ok;
            r_underflow <= re && !w_pop_ok;
        end
    end

    assign w_status = '{
        full:         w_full,
        empty:        w_empty,
        almost_full:  (r_count >= c_af_cnt),
        almost_empty: (r_count <= c_ae_cnt),
        overflow:     r_overflow,
        underflow:    r_underflow
    };

    assign data_out     = w_empty ? '0 : r_mem[w_rd_ptr];
    assign full         = w_status.full;
    assign empty        = w_status.empty;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;
    assign overflow     = w_status.overflow;
    assign underflow    = w_status.underflow;
    assign count        = r_count;

endmodule : fifo_sync
`default_nettype wire
